dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
//
// PURPOSE
//  Two-requester arbiter/sequencer for the single-port 8-bit x 1024 data memory (registered read, write on posedge).
//  Accepts one read or write command per handshake from either port, issues it to the memory and
//  returns a one-cycle response pulse (read data or write ack) to the requesting port.
//  Sits between the core load/store path (port 0) and the DMA/loader path (port 1) and the memory.
//
// PARAMETERS
//  ADDR_W      10  memory address width
//  DATA_W      8   memory data width
//  FIXED_PRIO  0   0 = round-robin between ports; 1 = port 0 always wins ties
//
// PORTS  (pN_* exists for N = 0 and N = 1)
//  clk           in   1       clock, all state on posedge
//  reset         in   1       asynchronous, active-high reset
//  pN_valid      in   1       port N command valid
//  pN_we         in   1       1 = write, 0 = read
//  pN_addr       in   ADDR_W  command address
//  pN_wdata      in   DATA_W  write data
//  pN_ready      out  1       port N command accepted this cycle (valid & ready at posedge)
//  pN_rsp_valid  out  1       one-cycle response pulse to port N
//  pN_rsp_rdata  out  DATA_W  read data (valid with rsp pulse on reads; 0 on write acks)
//  mem_we        out  1       to memory WriteEn
//  mem_re        out  1       to memory ReadEn
//  mem_addr      out  ADDR_W  to memory Address
//  mem_wdata     out  DATA_W  to memory WriteData
//  mem_rdata     in   DATA_W  from memory ReadData (updated at the posedge that samples mem_re)
//  busy          out  1       high in any state other than IDLE
//  grant         out  1       id of port owning the current/last transaction
//
// BEHAVIOUR
//  - Reset (async): state=IDLE; all outputs 0; last_grant=1 (port 0 wins the first tie); cmd regs 0.
//  - FSM: IDLE -> ISSUE -> (read: CAPT -> RESP | write: RESP) -> IDLE. No pipelining; one op in flight.
//  - IDLE: pN_ready is combinational, asserted only for the selected port and only while pN_valid is high.
//    Selection: one valid -> that port; both valid -> FIXED_PRIO=1: port 0; FIXED_PRIO=0: port != last_grant.
//    On the handshake edge: latch we/addr/wdata, set grant and last_grant to the winner, go to ISSUE.
//    pN_ready is never high outside IDLE; a waiting port keeps pN_valid and its command stable.
//  - ISSUE (1 cycle): mem_addr/mem_wdata = latched cmd; mem_we = cmd_we; mem_re = !cmd_we.
//    mem_we/mem_re are low in every other state; mem_addr/mem_wdata hold last cmd (no glitching).
//  - CAPT (reads, 1 cycle): at its closing edge pN_rsp_rdata <= mem_rdata for the granted port.
//  - RESP (1 cycle): pN_rsp_valid=1 for the granted port only; other port's rsp_valid stays 0.
//    Write ack: rsp_rdata = 0. rsp_rdata holds its value until the next response to that port.
//  - Latency from handshake edge E0: write -> mem_we in cycle after E0, rsp_valid 2 cycles after E0;
//    read -> mem_re in cycle after E0, rsp_valid with data 3 cycles after E0.
//    Throughput: one write per 3 cycles, one read per 4 cycles.
//  - Responses are not back-pressured; the requester must take the pulse.
//  - Address is passed through unmodified: 0 and 2^ADDR_W-1 are both legal, no wrap logic.
//  - A new request arriving while busy waits; arbitration uses the valids sampled in the next IDLE cycle.
//  - Reset mid-operation: FSM to IDLE immediately, mem_we/mem_re drop, no response is produced.
//    A write interrupted in ISSUE is not guaranteed to land. Memory contents are not cleared.
//
// TESTING
//  1. p0 write addr=5 data=97 -> p0_ready 1 cycle; mem_we=1, addr=5, wdata=97 for exactly 1 cycle;
//     p0_rsp_valid pulse 2 cycles after handshake, rdata=0.
//  2. p0 read addr=5 after test 1 -> mem_re 1 cycle; p0_rsp_valid 3 cycles after handshake with rdata=97;
//     p1_rsp_valid stays 0.
//  3. FIXED_PRIO=0, both ports hold valid for 4 reads (addr 1..4) -> grant order 0,1,0,1;
//     busy low exactly 1 cycle between ops.
//  4. FIXED_PRIO=1, both valid continuously -> port 0 served every time; p1 served only after p0_valid drops.
//  5. Write 0xAA to addr=1023 and 0x55 to addr=0, read both back -> 0xAA and 0x55, no aliasing.
//  6. Assert reset during CAPT of a read -> outputs 0 asynchronously, no rsp pulse;
//     after release, the next op completes normally and port 0 wins the first tie.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for a single-port registered-read data memory; one op in flight.
// Write: ack 2 cycles after handshake; read: data 3 cycles after. Responses are never back-pressured.
module dmem_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 8,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_valid,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ready,
  output logic              p0_rsp_valid,
  output logic [DATA_W-1:0] p0_rsp_rdata,
  input  logic              p1_valid,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ready,
  output logic              p1_rsp_valid,
  output logic [DATA_W-1:0] p1_rsp_rdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;

  state_t              state_q, state_d;
  logic                cmd_we_q, cmd_we_d;
  logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
  logic                grant_q, grant_d;
  logic                last_grant_q, last_grant_d;
  logic [DATA_W-1:0]   rsp0_q, rsp0_d;
  logic [DATA_W-1:0]   rsp1_q, rsp1_d;
  logic                sel;
  logic                handshake;

  // Tie-break: fixed priority favours port 0, otherwise the port not served last.
  always_comb begin
    sel = 1'b0;
    if (p0_valid && p1_valid) begin
      sel = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_q;
    end else if (p1_valid) begin
      sel = 1'b1;
    end
  end

  assign handshake = (state_q == IDLE) && (p0_valid || p1_valid);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (handshake) state_d = ISSUE;
      ISSUE:   state_d = cmd_we_q ? RESP : CAPT;
      CAPT:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    p0_ready     = (state_q == IDLE) && p0_valid && !sel;
    p1_ready     = (state_q == IDLE) && p1_valid && sel;
    mem_we       = (state_q == ISSUE) && cmd_we_q;
    mem_re       = (state_q == ISSUE) && !cmd_we_q;
    p0_rsp_valid = (state_q == RESP) && !grant_q;
    p1_rsp_valid = (state_q == RESP) && grant_q;
    busy         = (state_q != IDLE);
  end

  always_comb begin
    cmd_we_d     = cmd_we_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_wdata_d  = cmd_wdata_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    rsp0_d       = rsp0_q;
    rsp1_d       = rsp1_q;
    if (handshake) begin
      grant_d      = sel;
      last_grant_d = sel;
      cmd_we_d     = sel ? p1_we    : p0_we;
      cmd_addr_d   = sel ? p1_addr  : p0_addr;
      cmd_wdata_d  = sel ? p1_wdata : p0_wdata;
    end
    // Write acks carry zero data; read data is taken while the memory output is stable.
    if (state_q == ISSUE && cmd_we_q) begin
      if (grant_q) rsp1_d = '0;
      else         rsp0_d = '0;
    end
    if (state_q == CAPT) begin
      if (grant_q) rsp1_d = mem_rdata;
      else         rsp0_d = mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_we_q     <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      rsp0_q       <= '0;
      rsp1_q       <= '0;
    end else begin
      cmd_we_q     <= cmd_we_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      rsp0_q       <= rsp0_d;
      rsp1_q       <= rsp1_d;
    end
  end

  assign mem_addr     = cmd_addr_q;
  assign mem_wdata    = cmd_wdata_q;
  assign grant        = grant_q;
  assign p0_rsp_rdata = rsp0_q;
  assign p1_rsp_rdata = rsp1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: instance 0 round-robin, instance 1 fixed priority, each with its own memory.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0][1:0]       v, we, rdy, rv;
  logic [1:0][1:0][9:0]  ad;
  logic [1:0][1:0][7:0]  wd, rd;
  logic [1:0]            mwe, mre, bsy, gnt;
  logic [1:0][9:0]       ma;
  logic [1:0][7:0]       mwd;
  logic [7:0]            ref_mem [2][1024];
  logic [9:0]            aset [7] = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd1023};
  int                    n_cmp = 0;
  int                    n_bad = 0;
  int                    ord_q[$];
  int                    gap_q[$];

  for (genvar k = 0; k < 2; k++) begin : g_dut
    logic [7:0] mem [1024];
    logic [7:0] mrd;
    always @(posedge clk) begin
      if (mre[k]) mrd <= mem[ma[k]];
      if (mwe[k]) mem[ma[k]] <= mwd[k];
    end
    dmem_arbiter #(.ADDR_W(10), .DATA_W(8), .FIXED_PRIO(k)) u_dut (
      .clk(clk), .reset(reset),
      .p0_valid(v[k][0]), .p0_we(we[k][0]), .p0_addr(ad[k][0]), .p0_wdata(wd[k][0]),
      .p0_ready(rdy[k][0]), .p0_rsp_valid(rv[k][0]), .p0_rsp_rdata(rd[k][0]),
      .p1_valid(v[k][1]), .p1_we(we[k][1]), .p1_addr(ad[k][1]), .p1_wdata(wd[k][1]),
      .p1_ready(rdy[k][1]), .p1_rsp_valid(rv[k][1]), .p1_rsp_rdata(rd[k][1]),
      .mem_we(mwe[k]), .mem_re(mre[k]), .mem_addr(ma[k]), .mem_wdata(mwd[k]),
      .mem_rdata(mrd), .busy(bsy[k]), .grant(gnt[k]));
  end

  typedef struct {
    int         k;
    int         p;
    logic       w;
    logic [9:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Single isolated op; starts and ends just after a rising edge.
  task automatic run_op(input vec_t t);
    int n;
    v[t.k][t.p] = 1'b1; we[t.k][t.p] = t.w; ad[t.k][t.p] = t.a; wd[t.k][t.p] = t.d;
    n = 0;
    @(negedge clk);
    while (!rdy[t.k][t.p] && n < 20) begin @(negedge clk); n++; end
    chk("op_ready", rdy[t.k], t.p ? 2'b10 : 2'b01);
    @(posedge clk); #1;
    v[t.k][t.p] = 1'b0;
    if (t.w) ref_mem[t.k][t.a] = t.d;
    @(negedge clk);
    chk("issue_we", mwe[t.k], t.w);
    chk("issue_re", mre[t.k], !t.w);
    chk("issue_addr", ma[t.k], t.a);
    if (t.w) chk("issue_wdata", mwd[t.k], t.d);
    chk("issue_rsp_ready", {rv[t.k], rdy[t.k]}, 4'b0000);
    chk("issue_busy", bsy[t.k], 1'b1);
    if (!t.w) begin
      @(negedge clk);
      chk("capt_quiet", {mwe[t.k], mre[t.k], rv[t.k]}, 4'b0000);
    end
    @(negedge clk);
    chk("rsp_valid", rv[t.k], t.p ? 2'b10 : 2'b01);
    chk("rsp_rdata", rd[t.k][t.p], t.exp);
    chk("rsp_grant", gnt[t.k], t.p);
    chk("rsp_mem_idle", {mwe[t.k], mre[t.k]}, 2'b00);
    @(negedge clk);
    chk("after_rsp", {bsy[t.k], rv[t.k]}, 3'b000);
    @(posedge clk); #1;
  endtask

  // Both ports present back-to-back reads; records grant order and handshake spacing.
  task automatic contend(input int k, input int n0, input int n1, output int lowcnt);
    int idx[2];
    int cnt[2];
    int nrsp, nhs, last_hs;
    logic [1:0] hs;
    logic [7:0] eq0[$];
    logic [7:0] eq1[$];
    ord_q.delete(); gap_q.delete();
    idx = '{0, 0}; cnt = '{n0, n1};
    nrsp = 0; nhs = 0; last_hs = 0; lowcnt = 0;
    for (int c = 0; c < 100 && nrsp < n0 + n1; c++) begin
      for (int p = 0; p < 2; p++) begin
        v[k][p] = (idx[p] < cnt[p]); we[k][p] = 1'b0; wd[k][p] = 8'h00;
        ad[k][p] = 10'(1 + p + 2 * idx[p]);
      end
      @(negedge clk);
      if (nhs > 0 && nhs < n0 + n1 && !bsy[k]) lowcnt++;
      for (int p = 0; p < 2; p++) begin
        hs[p] = v[k][p] && rdy[k][p];
        if (hs[p]) begin
          ord_q.push_back(p);
          if (nhs > 0) gap_q.push_back(c - last_hs);
          last_hs = c; nhs++;
          if (p == 0) eq0.push_back(ref_mem[k][ad[k][p]]);
          else        eq1.push_back(ref_mem[k][ad[k][p]]);
        end
        if (rv[k][p]) begin
          nrsp++;
          if (p == 0 && eq0.size() > 0)      chk("cont_rdata0", rd[k][0], eq0.pop_front());
          else if (p == 1 && eq1.size() > 0) chk("cont_rdata1", rd[k][1], eq1.pop_front());
          else                               chk("cont_spurious_rsp", rv[k][p], 1'b0);
        end
      end
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) if (hs[p]) idx[p]++;
    end
    chk("cont_all_rsp", nrsp, n0 + n1);
    v[k] = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl [15];
    int   lc, exp_rr[4], exp_fp[4], exp_t6[2];
    int   free_at, win, lat;
    int   rsp_at[2];
    logic [7:0] rsp_dat[2];
    logic lg;
    logic [1:0] exp_rdy, exp_rv, hs;

    for (int k = 0; k < 2; k++) for (int i = 0; i < 1024; i++) ref_mem[k][i] = 8'h00;
    tbl[0]  = '{1, 0, 1'b1, 10'd1,    8'h21, 8'h00};
    tbl[1]  = '{1, 1, 1'b1, 10'd2,    8'h22, 8'h00};
    tbl[2]  = '{1, 0, 1'b1, 10'd3,    8'h23, 8'h00};
    tbl[3]  = '{1, 1, 1'b1, 10'd5,    8'h25, 8'h00};
    tbl[4]  = '{1, 1, 1'b0, 10'd5,    8'h00, 8'h25};
    tbl[5]  = '{0, 0, 1'b1, 10'd5,    8'd97, 8'h00};
    tbl[6]  = '{0, 0, 1'b0, 10'd5,    8'h00, 8'd97};
    tbl[7]  = '{0, 1, 1'b1, 10'd1023, 8'hAA, 8'h00};
    tbl[8]  = '{0, 0, 1'b1, 10'd0,    8'h55, 8'h00};
    tbl[9]  = '{0, 1, 1'b0, 10'd1023, 8'h00, 8'hAA};
    tbl[10] = '{0, 0, 1'b0, 10'd0,    8'h00, 8'h55};
    tbl[11] = '{0, 0, 1'b1, 10'd1,    8'h11, 8'h00};
    tbl[12] = '{0, 1, 1'b1, 10'd2,    8'h22, 8'h00};
    tbl[13] = '{0, 0, 1'b1, 10'd3,    8'h33, 8'h00};
    tbl[14] = '{0, 1, 1'b1, 10'd4,    8'h44, 8'h00};
    exp_rr = '{0, 1, 0, 1};
    exp_fp = '{0, 0, 0, 1};
    exp_t6 = '{0, 1};

    reset = 1'b1; v = '0; we = '0; ad = '0; wd = '0;
    #12;
    for (int k = 0; k < 2; k++) begin
      chk("reset_handshake", {rdy[k], rv[k], mwe[k], mre[k], bsy[k], gnt[k]}, 0);
      chk("reset_data", {rd[k], ma[k], mwd[k]}, 0);
    end
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 15; i++) run_op(tbl[i]);

    // Round-robin, both ports saturated.
    contend(0, 2, 2, lc);
    chk("rr_count", ord_q.size(), 4);
    for (int i = 0; i < 4; i++) chk("rr_order", (i < ord_q.size()) ? ord_q[i] : 99, exp_rr[i]);
    foreach (gap_q[i]) chk("rr_gap", gap_q[i], 4);
    chk("rr_busy_low", lc, 3);

    // Fixed priority: port 1 waits until port 0 stops asking.
    contend(1, 3, 1, lc);
    chk("fp_count", ord_q.size(), 4);
    for (int i = 0; i < 4; i++) chk("fp_order", (i < ord_q.size()) ? ord_q[i] : 99, exp_fp[i]);
    chk("fp_busy_low", lc, 3);

    // Reset in the capture cycle of a read.
    v[0][0] = 1'b1; we[0][0] = 1'b0; ad[0][0] = 10'd5; wd[0][0] = 8'h00;
    @(negedge clk);
    chk("t6_ready", rdy[0][0], 1'b1);
    @(posedge clk); #1;
    v[0][0] = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("t6_busy", bsy[0], 1'b0);
    chk("t6_mem", {mwe[0], mre[0]}, 2'b00);
    chk("t6_rsp", rv[0], 2'b00);
    chk("t6_rdata", {rd[0][0], rd[0][1]}, 16'h0000);
    chk("t6_grant_addr", {gnt[0], ma[0]}, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_no_rsp", rv[0], 2'b00);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    contend(0, 1, 1, lc);
    for (int i = 0; i < 2; i++) chk("t6_order", (i < ord_q.size()) ? ord_q[i] : 99, exp_t6[i]);

    // Random traffic on the round-robin instance against a timeline model.
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    lg = 1'b1; free_at = 0; rsp_at = '{-1, -1}; rsp_dat = '{8'h00, 8'h00};
    for (int now = 0; now < 400; now++) begin
      for (int p = 0; p < 2; p++) begin
        if (!v[0][p] && $urandom_range(0, 1) == 1) begin
          v[0][p] = 1'b1; we[0][p] = 1'($urandom_range(0, 1));
          ad[0][p] = aset[$urandom_range(0, 6)]; wd[0][p] = 8'($urandom);
        end
      end
      @(negedge clk);
      exp_rdy = 2'b00;
      if (now >= free_at && (v[0][0] || v[0][1])) begin
        win = (v[0][0] && v[0][1]) ? int'(!lg) : (v[0][1] ? 1 : 0);
        exp_rdy[win] = 1'b1; lg = 1'(win);
        lat = we[0][win] ? 2 : 3;
        rsp_at[win]  = now + lat;
        rsp_dat[win] = we[0][win] ? 8'h00 : ref_mem[0][ad[0][win]];
        if (we[0][win]) ref_mem[0][ad[0][win]] = wd[0][win];
        free_at = now + lat + 1;
      end
      chk("rnd_ready", rdy[0], exp_rdy);
      exp_rv = {rsp_at[1] == now, rsp_at[0] == now};
      chk("rnd_rsp_valid", rv[0], exp_rv);
      for (int p = 0; p < 2; p++) if (exp_rv[p]) chk("rnd_rdata", rd[0][p], rsp_dat[p]);
      hs = v[0] & rdy[0];
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) if (hs[p]) v[0][p] = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
